// File: rtl/ldst_sequencer.sv
// Multicycle LDR/STR/LDRB/STRB sequencer: effective address, memory req/ack handshake,
// then base and destination writeback through the shared register-file write port.
module ldst_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_byte,
  input  logic        pre_idx,
  input  logic        up,
  input  logic        wb,
  input  logic [31:0] rn_val,
  input  logic [11:0] imm12,
  input  logic [31:0] rd_val,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wr_en,
  output logic        wr_sel,
  output logic [31:0] wr_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 12;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_REQ, S_WB_RN, S_WB_RD, S_DONE, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic          ld_q, ld_d, byte_q, byte_d, pre_q, pre_d, up_q, up_d, wb_q, wb_d;
  logic [DW-1:0] rn_q, rn_d, rd_q, rd_d, ldata_q, ldata_d;
  logic [IW-1:0] imm_q, imm_d;
  logic [CW-1:0] wcnt_q, wcnt_d;

  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          wr_en_q, wr_en_d, wr_sel_q, wr_sel_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic [DW-1:0] ea_c, acc_c, ld_val_c;
  logic [7:0]    lane_c;
  logic          base_wb_c;

  // Address arithmetic and load-lane extraction from the latched instruction
  always_comb begin
    ea_c      = up_q ? rn_q + DW'(imm_q) : rn_q - DW'(imm_q);
    acc_c     = pre_q ? ea_c : rn_q;
    base_wb_c = wb_q | ~pre_q;
    case (acc_c[1:0])
      2'd0:    lane_c = mem_rdata[7:0];
      2'd1:    lane_c = mem_rdata[15:8];
      2'd2:    lane_c = mem_rdata[23:16];
      default: lane_c = mem_rdata[31:24];
    endcase
    ld_val_c = byte_q ? DW'(lane_c) : mem_rdata;
  end

  // Next state; outputs are derived from the next state so they leave as flops
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    byte_d  = byte_q;
    pre_d   = pre_q;
    up_d    = up_q;
    wb_d    = wb_q;
    rn_d    = rn_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    ldata_d = ldata_q;
    wcnt_d  = wcnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ld_d    = is_load;
          byte_d  = is_byte;
          pre_d   = pre_idx;
          up_d    = up;
          wb_d    = wb;
          rn_d    = rn_val;
          rd_d    = rd_val;
          imm_d   = imm12;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        wcnt_d  = '0;
        state_d = (!byte_q && acc_c[1:0] != 2'b00) ? S_ERR : S_REQ;
      end
      S_REQ: begin
        // An ack on the limit cycle still completes the access
        if (mem_ack) begin
          ldata_d = ld_val_c;
          if (base_wb_c)  state_d = S_WB_RN;
          else if (ld_q)  state_d = S_WB_RD;
          else            state_d = S_DONE;
        end else if (wcnt_q == CW'(TIMEOUT)) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_WB_RN: state_d = ld_q ? S_WB_RD : S_DONE;
      S_WB_RD: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_be_d    = '0;
    wr_en_d     = 1'b0;
    wr_sel_d    = 1'b0;
    wr_data_d   = '0;

    if (state_d == S_REQ) begin
      mem_req_d   = 1'b1;
      mem_we_d    = ~ld_q;
      mem_addr_d  = acc_c;
      mem_wdata_d = byte_q ? {4{rd_q[7:0]}} : rd_q;
      mem_be_d    = byte_q ? 4'(4'b0001 << acc_c[1:0]) : 4'b1111;
    end
    if (state_d == S_WB_RN) begin
      wr_en_d   = 1'b1;
      wr_sel_d  = 1'b1;
      wr_data_d = ea_c;
    end
    if (state_d == S_WB_RD) begin
      wr_en_d   = 1'b1;
      wr_data_d = ldata_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ld_q        <= 1'b0;
      byte_q      <= 1'b0;
      pre_q       <= 1'b0;
      up_q        <= 1'b0;
      wb_q        <= 1'b0;
      rn_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      ldata_q     <= '0;
      wcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ld_q        <= ld_d;
      byte_q      <= byte_d;
      pre_q       <= pre_d;
      up_q        <= up_d;
      wb_q        <= wb_d;
      rn_q        <= rn_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      ldata_q     <= ldata_d;
      wcnt_q      <= wcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign wr_en     = wr_en_q;
  assign wr_sel    = wr_sel_q;
  assign wr_data   = wr_data_q;

endmodule
